// File: rtl/warp_fetch_scheduler_if.sv
// Fetch-side bundle between the warp fetch scheduler and its environment
// (launch control, scoreboard stalls, decode feedback, instruction memory, decode output).
interface warp_fetch_scheduler_if #(
  parameter int unsigned NUM_WARPS     = 4,
  parameter int unsigned WARP_ID_WIDTH = 2,
  parameter int unsigned PC_WIDTH      = 8,
  parameter int unsigned INST_WIDTH    = 16
);
  logic                     launch_valid;
  logic [WARP_ID_WIDTH-1:0] launch_warp;
  logic [PC_WIDTH-1:0]      launch_pc;
  logic [NUM_WARPS-1:0]     stall_mask;
  logic                     redirect_valid;
  logic [WARP_ID_WIDTH-1:0] redirect_warp;
  logic [PC_WIDTH-1:0]      redirect_pc;
  logic                     halt_valid;
  logic [WARP_ID_WIDTH-1:0] halt_warp;
  logic [PC_WIDTH-1:0]      read_addr;
  logic [INST_WIDTH-1:0]    instruction;
  logic                     out_valid;
  logic                     out_ready;
  logic [INST_WIDTH-1:0]    out_inst;
  logic [WARP_ID_WIDTH-1:0] out_warp;
  logic [PC_WIDTH-1:0]      out_pc;
  logic [NUM_WARPS-1:0]     active_mask;

  // Scheduler side
  modport master (
    input  launch_valid, launch_warp, launch_pc, stall_mask,
    input  redirect_valid, redirect_warp, redirect_pc, halt_valid, halt_warp,
    output read_addr,
    input  instruction,
    output out_valid,
    input  out_ready,
    output out_inst, out_warp, out_pc, active_mask
  );

  // Environment side (launcher, scoreboard, instruction memory, decode)
  modport slave (
    output launch_valid, launch_warp, launch_pc, stall_mask,
    output redirect_valid, redirect_warp, redirect_pc, halt_valid, halt_warp,
    input  read_addr,
    output instruction,
    input  out_valid,
    output out_ready,
    input  out_inst, out_warp, out_pc, active_mask
  );
endinterface

// File: rtl/warp_fetch_scheduler.sv
// Per-warp PC owner and round-robin fetch arbiter; captures one instruction per
// cycle from a combinational instruction memory into a valid/ready output register.
module warp_fetch_scheduler #(
  parameter int unsigned NUM_WARPS     = 4,
  parameter int unsigned WARP_ID_WIDTH = 2,
  parameter int unsigned PC_WIDTH      = 8,
  parameter int unsigned INST_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  warp_fetch_scheduler_if.master bus
);
  localparam logic [WARP_ID_WIDTH-1:0] LAST_WARP = WARP_ID_WIDTH'(NUM_WARPS - 1);
  localparam logic [PC_WIDTH-1:0]      PC_STEP   = PC_WIDTH'(2);
  localparam logic [PC_WIDTH-1:0]      PC_ALIGN  = ~PC_WIDTH'(1);

  logic [NUM_WARPS-1:0]     active_q, active_d;
  logic [PC_WIDTH-1:0]      pc_q [NUM_WARPS];
  logic [PC_WIDTH-1:0]      pc_d [NUM_WARPS];
  logic [WARP_ID_WIDTH-1:0] rr_last_q, rr_last_d;
  logic                     out_valid_q, out_valid_d;
  logic [INST_WIDTH-1:0]    out_inst_q, out_inst_d;
  logic [WARP_ID_WIDTH-1:0] out_warp_q, out_warp_d;
  logic [PC_WIDTH-1:0]      out_pc_q, out_pc_d;

  logic [NUM_WARPS-1:0]     eligible;
  logic [WARP_ID_WIDTH-1:0] grant;
  logic [WARP_ID_WIDTH-1:0] probe;
  logic                     any_eligible;
  logic                     load;
  logic                     halt_ok;
  logic                     redirect_ok;
  logic                     launch_ok;
  logic                     held;
  logic                     flush;

  // A warp touched by a redirect or halt this cycle must not fetch from its stale PC
  always_comb begin
    eligible = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      eligible[w] = active_q[w] & ~bus.stall_mask[w]
                  & ~(bus.redirect_valid & (bus.redirect_warp == WARP_ID_WIDTH'(w)))
                  & ~(bus.halt_valid & (bus.halt_warp == WARP_ID_WIDTH'(w)));
    end
  end

  // Round-robin search starting just after the last granted warp
  always_comb begin
    grant        = rr_last_q;
    probe        = rr_last_q;
    any_eligible = 1'b0;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      probe = rr_last_q + WARP_ID_WIDTH'(i);
      if (!any_eligible && eligible[probe]) begin
        grant        = probe;
        any_eligible = 1'b1;
      end
    end
  end

  assign load          = (~out_valid_q | bus.out_ready) & any_eligible;
  assign bus.read_addr = load ? pc_q[grant] : pc_q[rr_last_q];

  // Halt dominates redirect on the same warp; launch only lands on an idle warp
  assign halt_ok     = bus.halt_valid & active_q[bus.halt_warp];
  assign redirect_ok = bus.redirect_valid & active_q[bus.redirect_warp]
                     & ~(bus.halt_valid & (bus.halt_warp == bus.redirect_warp));
  assign launch_ok   = bus.launch_valid & ~active_q[bus.launch_warp];
  assign held        = out_valid_q & ~bus.out_ready;
  assign flush       = held & ((redirect_ok & (out_warp_q == bus.redirect_warp))
                             | (halt_ok & (out_warp_q == bus.halt_warp)));

  always_comb begin
    active_d    = active_q;
    pc_d        = pc_q;
    rr_last_d   = rr_last_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_warp_d  = out_warp_q;
    out_pc_d    = out_pc_q;

    if (load) begin
      out_valid_d = 1'b1;
      out_inst_d  = bus.instruction;
      out_warp_d  = grant;
      out_pc_d    = pc_q[grant];
      pc_d[grant] = pc_q[grant] + PC_STEP;
      rr_last_d   = grant;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (redirect_ok) begin
      pc_d[bus.redirect_warp] = bus.redirect_pc & PC_ALIGN;
    end
    if (halt_ok) begin
      active_d[bus.halt_warp] = 1'b0;
    end
    if (launch_ok) begin
      active_d[bus.launch_warp] = 1'b1;
      pc_d[bus.launch_warp]     = bus.launch_pc & PC_ALIGN;
    end
    if (flush) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q    <= '0;
      rr_last_q   <= LAST_WARP;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_warp_q  <= '0;
      out_pc_q    <= '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        pc_q[w] <= '0;
      end
    end else begin
      active_q    <= active_d;
      rr_last_q   <= rr_last_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_warp_q  <= out_warp_d;
      out_pc_q    <= out_pc_d;
      for (int w = 0; w < NUM_WARPS; w++) begin
        pc_q[w] <= pc_d[w];
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_inst    = out_inst_q;
  assign bus.out_warp    = out_warp_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.active_mask = active_q;

endmodule

// File: doc/warp_fetch_scheduler.md
# warp_fetch_scheduler

Per-warp program-counter owner and round-robin fetch arbiter for the compute unit's instruction memory. Each cycle it picks one eligible warp, drives that warp's PC onto the instruction memory's combinational per-warp read port, and captures the returned 16-bit instruction into a one-entry output register. The output register feeds decode through a valid/ready handshake. Decode reports branch redirects and warp halts back to this block.

## Interface
- NUM_WARPS, 4, number of hardware warps (power of two, ≥2)
- WARP_ID_WIDTH, 2, log2(NUM_WARPS)
- PC_WIDTH, 8, byte-addressed PC width (matches instruction memory read_addr)
- INST_WIDTH, 16, instruction width
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- launch_valid  input  1  launch request for the warp named by launch_warp
- launch_warp  input  WARP_ID_WIDTH  warp to launch
- launch_pc  input  PC_WIDTH  start PC for the launched warp
- stall_mask  input  NUM_WARPS  bit w=1 excludes warp w from selection this cycle (scoreboard)
- redirect_valid  input  1  branch redirect
- redirect_warp  input  WARP_ID_WIDTH  redirected warp
- redirect_pc  input  PC_WIDTH  new PC
- halt_valid  input  1  warp finished
- halt_warp  input  WARP_ID_WIDTH  halting warp
- read_addr  output  PC_WIDTH  to instruction memory read_addr (combinational)
- instruction  input  INST_WIDTH  from instruction memory, same cycle as read_addr
- out_valid  output  1  output register holds an instruction
- out_ready  input  1  decode accepts
- out_inst  output  INST_WIDTH  fetched instruction
- out_warp  output  WARP_ID_WIDTH  owning warp
- out_pc  output  PC_WIDTH  PC of out_inst
- active_mask  output  NUM_WARPS  registered per-warp active bits

## Operation
- State: active[w], pc[w], rr_last (last granted warp), output register (valid, inst, warp, pc).
- Eligible(w) = active[w] & ~stall_mask[w] & ~(redirect_valid & redirect_warp==w) & ~(halt_valid & halt_warp==w).
- Load enable: load = (~out_valid | out_ready) & any eligible.
- Grant: the first eligible warp searching rr_last+1, rr_last+2, … mod NUM_WARPS. read_addr = pc[grant] when load=1, else pc[rr_last]. The fallback value has no effect.
- On load: the output register ← {instruction, grant, pc[grant]}, pc[grant] ← pc[grant]+2 mod 2^PC_WIDTH (so 0xFE wraps to 0x00), and rr_last ← grant.
- When out_valid & out_ready & ~load, out_valid ← 0.
- Redirect: pc[redirect_warp] ← redirect_pc. If the output register holds redirect_warp and is not being accepted this cycle, it is flushed (out_valid ← 0). A redirect to an inactive warp is ignored.
- Halt: active[halt_warp] ← 0, with the same flush rule as redirect. Halt of an inactive warp is a no-op.
- Launch: accepted only if active[launch_warp]=0 at the start of the cycle. On acceptance, active ← 1 and pc ← launch_pc. A launch to an active warp is ignored.
- Simultaneous events on the same warp:
  - Active warp with halt + launch: halt applies, launch is ignored.
  - Inactive warp with halt + launch: launch is accepted.
  - Halt + redirect: halt applies, redirect is ignored.
- Simultaneous events on different warps are all applied independently in one cycle.
- launch_pc and redirect_pc bit 0 is forced to 0 (2-byte alignment).

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, out_inst=0, out_warp=0, out_pc=0, active_mask=0, all pc[w]=0, rr_last=NUM_WARPS-1 (warp 0 is granted first).
- The instruction memory is combinational, so fetch latency is one cycle: the instruction is selected in cycle N and out_valid is visible in cycle N+1.
- Launch in cycle N: the warp is eligible in N+1, and its first instruction is on the outputs in N+2.
- Redirect in cycle N: the warp is eligible in N+1 at the new PC.
- Throughput: one instruction per cycle while out_ready=1 and ≥1 warp is eligible.
- While out_valid=1 & out_ready=0, the outputs hold stable and no PC advances.
- A mid-operation rst_n assertion immediately clears all state and outputs. No partial fetch survives.

## Test plan
- Reset/launch: deassert rst_n, launch warp 0 at pc 0x10 with ROM[8]=0xA123, out_ready=1 -> out_valid rises 2 cycles later with out_inst=0xA123, out_pc=0x10, out_warp=0; active_mask=0001.
- Round-robin: launch warps 0–3 at 0x00/0x20/0x40/0x60, out_ready=1 -> out_warp sequence 0,1,2,3,0,… and out_pc 0x00,0x20,0x40,0x60,0x02,… ; stall_mask=0010 -> warp 1 is skipped and the sequence is 0,2,3,0.
- Backpressure: out_ready=0 for 3 cycles with an instruction held -> outputs are unchanged and no pc increments; release -> the next warp in order follows with no duplicate and no loss.
- Redirect flush: warp 2's instruction is held with out_ready=0, then redirect warp 2 to 0x80 -> out_valid drops next cycle; warp 2's next fetched out_pc=0x80.
- Halt/launch collision: active warp 1 gets halt + launch together -> active_mask bit 1=0 and launch is ignored; repeat on inactive warp 1 with launch_pc=0x30 -> bit 1=1, first out_pc=0x30.
- Wrap and async reset: warp 0 at 0xFE -> out_pc 0xFE then 0x00; drop rst_n mid-stream -> all outputs 0 at once, and the first grant after release is warp 0.
